// File: rtl/bubblesort_drain.sv
// Drain stage for the bubblesort core: snapshots the packed sorted result on done_i rising,
// streams it out over valid/ready, checks non-decreasing order and accumulates a checksum.
module bubblesort_drain #(
  parameter int unsigned NUM_ELEMS = 49,
  parameter int unsigned ELEM_W    = 8,
  parameter int unsigned CSUM_W    = ELEM_W + $clog2(NUM_ELEMS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          done_i,
  input  logic [NUM_ELEMS*ELEM_W-1:0]   readdata_i,
  output logic [ELEM_W-1:0]             m_data_o,
  output logic                          m_valid_o,
  input  logic                          m_ready_i,
  output logic                          m_last_o,
  output logic                          busy_o,
  output logic                          frame_done_o,
  output logic                          order_err_o,
  output logic [CSUM_W-1:0]             checksum_o
);

  localparam int unsigned IDX_W = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMS - 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FINISH
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              done_q;
  logic              start;
  logic              accept;
  logic              is_last;
  logic [IDX_W-1:0]  index;
  logic [ELEM_W-1:0] shadow [NUM_ELEMS];
  logic [ELEM_W-1:0] elem;
  logic [ELEM_W-1:0] prev;
  logic [CSUM_W-1:0] acc;
  logic [CSUM_W-1:0] acc_next;
  logic              err;
  logic              err_next;

  assign start    = done_i && !done_q;
  assign elem     = shadow[index];
  assign is_last  = (index == LAST_IDX);
  assign accept   = (state == STREAM) && m_ready_i;
  assign acc_next = acc + CSUM_W'(elem);
  assign err_next = err || ((index != '0) && (elem < prev));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Outputs depend on state and registers only, never on m_ready_i.
  always_comb begin
    state_next   = state;
    m_valid_o    = 1'b0;
    busy_o       = 1'b0;
    m_data_o     = '0;
    m_last_o     = 1'b0;
    frame_done_o = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = STREAM;
        end
      end
      STREAM: begin
        m_valid_o = 1'b1;
        busy_o    = 1'b1;
        m_data_o  = elem;
        m_last_o  = is_last;
        if (m_ready_i && is_last) begin
          state_next = FINISH;
        end
      end
      FINISH: begin
        frame_done_o = 1'b1;
        state_next   = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      for (int unsigned i = 0; i < NUM_ELEMS; i++) begin
        shadow[i] <= readdata_i[i*ELEM_W +: ELEM_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      done_q      <= 1'b1;
      index       <= '0;
      acc         <= '0;
      err         <= 1'b0;
      prev        <= '0;
      checksum_o  <= '0;
      order_err_o <= 1'b0;
    end else begin
      done_q <= done_i;
      if (state == IDLE && start) begin
        index <= '0;
        acc   <= '0;
        err   <= 1'b0;
      end else if (accept) begin
        acc  <= acc_next;
        err  <= err_next;
        prev <= elem;
        // Results are published with the final beat's contribution folded in, so they
        // become visible on the same edge that raises frame_done_o.
        if (is_last) begin
          checksum_o  <= acc_next;
          order_err_o <= err_next;
        end else begin
          index <= index + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/bubblesort_drain.md
# bubblesort_drain

Downstream stage of the bubblesort core. It snapshots the sorter's 49-element packed result when the sorter signals completion, streams the elements out one per beat over a valid/ready interface, and checks that the sequence is non-decreasing. It also accumulates a checksum, giving the OOC harness an observable, sequentially driven consumer of the sort result instead of a dangling wide bus.

## Interface
Parameters:
- NUM_ELEMS, 49, number of elements in the packed result
- ELEM_W, 8, element width in bits
- CSUM_W, ELEM_W + $clog2(NUM_ELEMS) (14), checksum width; must hold NUM_ELEMS*(2^ELEM_W-1) without overflow

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-low reset (asserted when 0)
- done_i  in  1  sorter completion level (bubblesort done_o)
- readdata_i  in  NUM_ELEMS*ELEM_W  packed sorted result; element i = readdata_i[i*ELEM_W +: ELEM_W]
- m_data_o  out  ELEM_W  current element
- m_valid_o  out  1  m_data_o valid
- m_ready_i  in  1  sink accepts the beat when m_valid_o && m_ready_i
- m_last_o  out  1  high with the beat of element NUM_ELEMS-1
- busy_o  out  1  high while a frame is captured and not fully drained
- frame_done_o  out  1  one-cycle pulse after the last beat is accepted
- order_err_o  out  1  result flag of the last completed frame: 1 = some element < its predecessor
- checksum_o  out  CSUM_W  unsigned sum of all elements of the last completed frame

## Operation
- Every output resets to 0. Internal state also resets: state=IDLE, index=0, accumulator=0, sticky error=0, done_q=1. done_q=1 means a done_i held high across reset release does not start a frame.
- Start condition: start = done_i && !done_q, where done_q is done_i registered each cycle.
- FSM has three states:
  - IDLE: on start, copy readdata_i into the shadow register, set index=0, clear the accumulator and sticky error, and go to STREAM. Otherwise stay.
  - STREAM:
    - m_valid_o=1 and busy_o=1.
    - m_data_o = shadow element[index]. m_last_o = (index == NUM_ELEMS-1).
    - On an accepted beat: add the zero-extended element to the accumulator. If index>0 and element < prev, set the sticky error. Record prev = element.
    - On an accepted beat that is not last: index++.
    - On an accepted beat that is last: go to FINISH.
  - FINISH (one cycle): frame_done_o=1, checksum_o ← accumulator, order_err_o ← sticky error, busy_o=0. Then go to IDLE.
- checksum_o and order_err_o hold their values until the next FINISH. They do not change at frame start.
- Element comparison is unsigned. Equal adjacent elements are legal (non-decreasing).
- A start occurring in STREAM or FINISH is ignored and is not queued. readdata_i changes after capture have no effect on the frame.
- Reset asserted mid-frame: the frame is abandoned, all outputs return to 0 on the next edge, and no frame_done_o pulse is produced.

## Timing
- done_i rises and is first sampled high at edge N: capture happens at edge N. m_valid_o=1 with element 0 is visible after edge N.
- With m_ready_i held at 1: one beat per cycle, NUM_ELEMS beats back to back. The last beat is accepted at edge N+NUM_ELEMS.
- frame_done_o is high in the cycle after the last acceptance. checksum_o and order_err_o are updated on that same edge.
- Back-pressure: while m_valid_o && !m_ready_i, m_data_o, m_last_o and index are held stable. m_valid_o never drops inside a frame.
- Minimum start-to-start spacing is NUM_ELEMS+2 cycles. done_i must fall and rise again to start a new frame; a level held high does not retrigger.
- No combinational path from m_ready_i to m_valid_o or m_data_o.

## Test plan
- Sorted ramp: readdata_i element i = 2*i, pulse done_i, m_ready_i=1. Expect 49 beats 0,2,…,96, m_last_o only on 96, frame_done_o 50 cycles after capture, checksum_o=2352, order_err_o=0.
- Unsorted input: elements all 0x10 except element 20 = 0x05. Expect order_err_o=1, checksum_o=48*16+5=773. Then a sorted frame of all 0xFF: order_err_o=0, checksum_o=12495 (max, no overflow).
- Back-pressure: m_ready_i toggles 1,0,0,1 repeating. Data holds while stalled, no beat is lost or duplicated, and the checksum matches the ramp result.
- Retrigger and held done: done_i held high for 100 cycles, then a second rising edge during STREAM. Expect exactly one frame. readdata_i changed mid-frame does not alter the streamed data.
- Reset behaviour: rst=0 at beat 10. All outputs are 0 on the next cycle and no frame_done_o occurs. After release with done_i already high, no frame starts until done_i falls and rises.
- Stable results: after a frame, checksum_o and order_err_o keep their values through IDLE and through the next frame's STREAM until its FINISH.
